// File: rtl/sr_digit_shift_seq_if.sv
// Control/data bundle for the sequential digit shifter.
// The master side drives the request; the slave side is the shifter itself.
interface sr_digit_shift_seq_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 6
);
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             start;
   logic             dir;
   logic [1:0]       mode;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] data_out;
   logic             busy;
   logic             done;
   logic             zero;

   modport master (
      output data_in, load, start, dir, mode, count,
      input  data_out, busy, done, zero
   );

   modport slave (
      input  data_in, load, start, dir, mode, count,
      output data_out, busy, done, zero
   );
endinterface

// File: rtl/sr_digit_shift_seq.sv
// Parametrised sequential digit shifter: rotate / logical / arithmetic,
// one DIGIT per clock for a latched step count, with start/busy/done handshake.
module sr_digit_shift_seq #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIGIT = 4,
   parameter int unsigned CNT_W = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   sr_digit_shift_seq_if.slave  bus_io
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] step_val;

   // One DIGIT step of the latched operation; arithmetic left equals logical left.
   always_comb begin
      step_val = data_q;
      if (!dir_q) begin
         if (mode_q == 2'b01 || mode_q == 2'b10) begin
            step_val = {data_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
         end else begin
            step_val = {data_q[WIDTH-DIGIT-1:0], data_q[WIDTH-1:WIDTH-DIGIT]};
         end
      end else begin
         case (mode_q)
            2'b01:   step_val = {{DIGIT{1'b0}}, data_q[WIDTH-1:DIGIT]};
            2'b10:   step_val = {{DIGIT{data_q[WIDTH-1]}}, data_q[WIDTH-1:DIGIT]};
            default: step_val = {data_q[DIGIT-1:0], data_q[WIDTH-1:DIGIT]};
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      case (state_q)
         StIdle: begin
            if (bus_io.load) begin
               data_d = bus_io.data_in;
            end else if (bus_io.start) begin
               if (bus_io.count == '0) begin
                  state_d = StDone;
               end else begin
                  cnt_d   = bus_io.count;
                  dir_d   = bus_io.dir;
                  mode_d  = bus_io.mode;
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            data_d = step_val;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
      end
   end

   assign bus_io.data_out = data_q;
   assign bus_io.busy     = (state_q == StShift);
   assign bus_io.done     = (state_q == StDone);
   assign bus_io.zero     = (data_q == '0);

endmodule

// File: tb/tb_sr_digit_shift_seq.sv
// Scoreboard bench for sr_digit_shift_seq: 64/4 main instance plus an 8/1 instance.
module tb_sr_digit_shift_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sr_digit_shift_seq_if #(.WIDTH(64), .CNT_W(6)) if64 ();
   sr_digit_shift_seq_if #(.WIDTH(8),  .CNT_W(6)) if8 ();

   sr_digit_shift_seq #(.WIDTH(64), .DIGIT(4), .CNT_W(6)) u_dut (
      .CLK    (clk),
      .RST    (rst),
      .bus_io (if64)
   );

   sr_digit_shift_seq #(.WIDTH(8), .DIGIT(1), .CNT_W(6)) u_dut8 (
      .CLK    (clk),
      .RST    (rst),
      .bus_io (if8)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] model_q  = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference step model built from shift operators rather than slices.
   function automatic logic [63:0] model_shift(logic [63:0] v, logic d, logic [1:0] m, int n);
      for (int i = 0; i < n; i++) begin
         if (!d) begin
            if (m == 2'b01 || m == 2'b10) v = v << 4;
            else                          v = (v << 4) | (v >> 60);
         end else begin
            if (m == 2'b01)      v = v >> 4;
            else if (m == 2'b10) v = 64'($signed(v) >>> 4);
            else                 v = (v >> 4) | (v << 60);
         end
      end
      return v;
   endfunction

   task automatic load_val(input logic [63:0] v);
      if64.load    = 1'b1;
      if64.data_in = v;
      @(negedge clk);
      if64.load = 1'b0;
      model_q   = v;
      check_eq("load", if64.data_out, v);
   endtask

   // Issues one operation; with noise set, inputs are scrambled while SHIFT runs.
   task automatic run_op(input string tag, input logic d, input logic [1:0] m, input int n,
                         input bit noise);
      int cycles = 0;
      int busy_n = 0;
      bit seen   = 1'b0;
      logic [63:0] exp;
      if64.start = 1'b1;
      if64.dir   = d;
      if64.mode  = m;
      if64.count = 6'(n);
      model_q = model_shift(model_q, d, m, n);
      exp_q.push_back(model_q);
      while (!seen && cycles < n + 10) begin
         @(negedge clk);
         cycles++;
         if (if64.busy) busy_n++;
         if (if64.done) begin
            seen = 1'b1;
         end else if (noise) begin
            if64.load    = 1'($urandom);
            if64.start   = 1'($urandom);
            if64.dir     = ~if64.dir;
            if64.mode    = 2'($urandom);
            if64.count   = 6'($urandom);
            if64.data_in = {$urandom, $urandom};
         end else begin
            if64.start = 1'b0;
         end
      end
      if64.start = 1'b0;
      if64.load  = 1'b0;
      exp = exp_q.pop_front();
      check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
      check_eq({tag, "_data"}, if64.data_out, exp);
      check_eq({tag, "_latency"}, 64'(cycles), 64'(n + 1));
      check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'(n));
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 64'(if64.done), 64'd0);
   endtask

   initial begin
      int busy_seen;
      int dones;
      if64.data_in = '0; if64.load = 0; if64.start = 0; if64.dir = 0; if64.mode = 0;
      if64.count = '0;
      if8.data_in = '0; if8.load = 0; if8.start = 0; if8.dir = 0; if8.mode = 0; if8.count = '0;
      #1;
      check_eq("rst_data", if64.data_out, 64'd0);
      check_eq("rst_busy", 64'(if64.busy), 64'd0);
      check_eq("rst_done", 64'(if64.done), 64'd0);
      check_eq("rst_zero", 64'(if64.zero), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      load_val(64'h0123_4567_89AB_CDEF);
      check_eq("zero_nonzero", 64'(if64.zero), 64'd0);
      run_op("rotl1", 1'b0, 2'b00, 1, 1'b0);
      check_eq("rotl1_value", if64.data_out, 64'h1234_5678_9ABC_DEF0);
      load_val(64'h0123_4567_89AB_CDEF);
      run_op("rotr16", 1'b1, 2'b00, 16, 1'b0);
      check_eq("rotr16_value", if64.data_out, 64'h0123_4567_89AB_CDEF);

      load_val(64'hF000_0000_0000_0001);
      run_op("asr2", 1'b1, 2'b10, 2, 1'b0);
      check_eq("asr2_value", if64.data_out, 64'hFFF0_0000_0000_0000);
      load_val(64'hF000_0000_0000_0001);
      run_op("lsr2", 1'b1, 2'b01, 2, 1'b0);
      check_eq("lsr2_value", if64.data_out, 64'h00F0_0000_0000_0000);

      load_val(64'hDEAD_BEEF_CAFE_F00D);
      run_op("lsl20", 1'b0, 2'b01, 20, 1'b0);
      check_eq("lsl20_zero", 64'(if64.zero), 64'd1);
      load_val(64'h0000_1111_2222_3333);
      run_op("cnt0", 1'b0, 2'b00, 0, 1'b0);
      run_op("rot11r5", 1'b1, 2'b11, 5, 1'b0);
      run_op("asl3_noise", 1'b0, 2'b10, 3, 1'b1);
      load_val(64'h8765_4321_0000_0001);
      run_op("asr63", 1'b1, 2'b10, 63, 1'b0);
      run_op("rotl40_noise", 1'b0, 2'b00, 40, 1'b1);

      // start and load together: load wins
      if64.load = 1'b1; if64.start = 1'b1; if64.count = 6'd5;
      if64.data_in = 64'hA5A5_0000_5A5A_FFFF;
      @(negedge clk);
      if64.load = 1'b0; if64.start = 1'b0;
      model_q = 64'hA5A5_0000_5A5A_FFFF;
      check_eq("ldst_data", if64.data_out, model_q);
      check_eq("ldst_busy", 64'(if64.busy), 64'd0);
      @(negedge clk);
      check_eq("ldst_busy2", 64'(if64.busy), 64'd0);

      // reset during step 3 of a 10-step shift
      if64.start = 1'b1; if64.dir = 1'b0; if64.mode = 2'b00; if64.count = 6'd10;
      busy_seen = 0;
      for (int i = 0; i < 20 && busy_seen < 3; i++) begin
         @(negedge clk);
         if64.start = 1'b0;
         if (if64.busy) busy_seen++;
      end
      check_eq("abort_busy_before", 64'(busy_seen), 64'd3);
      #2 rst = 1'b1;
      #1;
      check_eq("abort_data", if64.data_out, 64'd0);
      check_eq("abort_busy", 64'(if64.busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (if64.done) dones++;
      end
      check_eq("abort_no_done", 64'(dones), 64'd0);
      check_eq("abort_data_after", if64.data_out, 64'd0);

      // 8-bit, 1-bit-digit build
      if8.load = 1'b1; if8.data_in = 8'h81;
      @(negedge clk);
      if8.load = 1'b0;
      if8.start = 1'b1; if8.dir = 1'b0; if8.mode = 2'b00; if8.count = 6'd1;
      @(negedge clk);
      if8.start = 1'b0;
      @(negedge clk);
      check_eq("w8_done", 64'(if8.done), 64'd1);
      check_eq("w8_rotl1", 64'(if8.data_out), 64'h03);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
